// File: rtl/switch_events.sv
`default_nettype none
// ============================================================================
// switch_events : debounced switch levels plus a queued press/release stream
// Rev 1.0
// ============================================================================
module switch_events #(
  parameter int WIDTH      = 16,
  parameter int DEBOUNCE   = 500,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       sw,
  output logic [WIDTH-1:0]       sw_stable,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [$clog2(WIDTH):0] ev_code,
  output logic                   overrun
);

  localparam int IW    = $clog2(WIDTH);
  localparam int CODEW = IW + 1;
  localparam int CW    = $clog2(DEBOUNCE);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NW    = AW + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);

  logic [WIDTH-1:0] sw_meta_q, sw_meta_d;
  logic [WIDTH-1:0] sw_sync_q, sw_sync_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] pdir_q, pdir_d;
  logic             overrun_q, overrun_d;
  logic [CODEW-1:0] mem_q [FIFO_DEPTH];
  logic [CODEW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] raise;
  logic [WIDTH-1:0] clr;
  logic [IW-1:0]    sel;
  logic             found;
  logic             full;
  logic             push;
  logic             pop;

  // Per-bit stability counter: a level change is accepted only after the
  // synchronized input has disagreed with sw_stable for DEBOUNCE straight edges.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_q, cnt_d;
      logic          differ;

      assign differ    = sw_sync_q[gi] ^ stable_q[gi];
      assign raise[gi] = differ && (cnt_q == CNT_LAST);

      always_comb begin
        cnt_d = '0;
        if (differ && !raise[gi]) cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

  always_comb begin
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    stable_d  = stable_q ^ raise;

    full = (count_q == FIFO_FULL);
    pop  = ev_valid && ev_ready;

    sel   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel   = IW'(i);
        found = 1'b1;
      end
    end
    // Full is judged on the pre-pop occupancy, so a same-cycle pop never makes room.
    push = found && !full;

    clr = '0;
    if (push) clr[sel] = 1'b1;

    // A fresh raise beats a same-cycle drain of the same bit.
    pend_d    = raise | (pend_q & ~clr);
    pdir_d    = (raise & stable_d) | (~raise & pdir_q);
    overrun_d = overrun_q | (|(raise & pend_q & ~clr));

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {pdir_q[sel], sel};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + NW'(push) - NW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      stable_q  <= '0;
      pend_q    <= '0;
      pdir_q    <= '0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      stable_q  <= stable_d;
      pend_q    <= pend_d;
      pdir_q    <= pdir_d;
      overrun_q <= overrun_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign sw_stable = stable_q;
  assign ev_valid  = (count_q != '0);
  assign ev_code   = mem_q[rd_ptr_q];
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_events.sv
`default_nettype none
// ============================================================================
// tb_switch_events : directed scenarios plus random switch activity, checked
// cycle by cycle against a window-based debounce / event-queue reference model
// Rev 1.0
// ============================================================================
module tb_switch_events;

  localparam int W     = 16;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  sw;
  logic [W-1:0]  sw_stable;
  logic          ev_valid;
  logic          ev_ready;
  logic [4:0]    ev_code;
  logic          overrun;

  int n_assert;
  int n_fail;

  // Reference model state
  logic [W-1:0] m_meta, m_sync, m_stable, m_pend, m_pdir;
  bit           m_ovr;
  logic [W-1:0] m_hist[$];
  logic [4:0]   m_q[$];

  switch_events #(.WIDTH(W), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .sw_stable (sw_stable),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_meta   = '0;
    m_sync   = '0;
    m_stable = '0;
    m_pend   = '0;
    m_pdir   = '0;
    m_ovr    = 1'b0;
    m_hist.delete();
    m_q.delete();
  endtask

  // A bit toggles once its synchronized level has disagreed with the stable
  // level on each of the last DEB edges.
  task automatic model_step(input logic [W-1:0] s, input logic rdy);
    logic [W-1:0] raised;
    logic [W-1:0] h;
    bit           all_diff;
    bit           done;
    int           old_n;
    raised = '0;
    old_n  = m_q.size();
    m_hist.push_back(m_sync);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          h = m_hist[k];
          if (h[i] == m_stable[i]) all_diff = 1'b0;
        end
        raised[i] = all_diff;
      end
    end
    m_stable = m_stable ^ raised;
    if (old_n > 0 && rdy) void'(m_q.pop_front());
    if (old_n < DEPTH) begin
      done = 1'b0;
      for (int i = 0; i < W; i++) begin
        if (!done && m_pend[i]) begin
          m_q.push_back({m_pdir[i], 4'(i)});
          m_pend[i] = 1'b0;
          done      = 1'b1;
        end
      end
    end
    for (int i = 0; i < W; i++) begin
      if (raised[i]) begin
        if (m_pend[i]) m_ovr = 1'b1;
        m_pend[i] = 1'b1;
        m_pdir[i] = m_stable[i];
      end
    end
    m_sync = m_meta;
    m_meta = s;
  endtask

  task automatic check_all();
    chk("sw_stable", 32'(sw_stable), 32'(m_stable));
    chk("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("ev_code", 32'(ev_code), 32'(m_q[0]));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(sw, ev_ready);
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    sw       = '0;
    ev_ready = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    chk("rst_stable", 32'(sw_stable), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_code", 32'(ev_code), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Single rise on bit 3
    sw[3] = 1'b1;
    cycles(5);
    chk("s1_stable_e5", 32'(sw_stable[3]), 32'd0);
    cycle();
    chk("s1_stable_e6", 32'(sw_stable[3]), 32'd1);
    cycle();
    chk("s1_valid", 32'(ev_valid), 32'd1);
    chk("s1_code", 32'(ev_code), 32'h13);
    ev_ready = 1'b1;
    cycle();
    ev_ready = 1'b0;
    chk("s1_popped", 32'(ev_valid), 32'd0);

    // Bouncing bit 0: 3 high, 1 low, then steady high
    sw[0] = 1'b1;
    cycles(3);
    sw[0] = 1'b0;
    cycle();
    sw[0] = 1'b1;
    cycles(5);
    chk("bounce_stable_e5", 32'(sw_stable[0]), 32'd0);
    cycle();
    chk("bounce_stable_e6", 32'(sw_stable[0]), 32'd1);
    cycle();
    chk("bounce_code", 32'(ev_code), 32'h10);
    ev_ready = 1'b1;
    cycle();
    ev_ready = 1'b0;
    chk("bounce_single", 32'(ev_valid), 32'd0);

    // Simultaneous rises on bits 5 and 2
    sw = sw | 16'h0024;
    cycles(7);
    chk("simul_first", 32'(ev_code), 32'h12);
    cycle();
    chk("simul_hold", 32'(ev_code), 32'h12);
    ev_ready = 1'b1;
    cycle();
    chk("simul_second", 32'(ev_code), 32'h15);
    cycle();
    chk("simul_empty", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;

    // Five events into a four-entry queue
    sw = sw | 16'h1F00;
    cycles(12);
    chk("full_overrun", 32'(overrun), 32'd0);
    chk("full_head", 32'(ev_code), 32'h18);
    ev_ready = 1'b1;
    cycle();
    ev_ready = 1'b0;
    chk("full_pop_head", 32'(ev_code), 32'h19);
    cycle();
    ev_ready = 1'b1;
    cycles(6);
    ev_ready = 1'b0;
    chk("full_drained", 32'(ev_valid), 32'd0);

    // Overrun: queue full, bit 7 rises then falls while still pending
    sw = sw & ~16'h0F00;
    cycles(12);
    sw[7] = 1'b1;
    cycles(8);
    sw[7] = 1'b0;
    cycles(8);
    chk("ovr_set", 32'(overrun), 32'd1);
    ev_ready = 1'b1;
    cycles(4);
    chk("ovr_last_event", 32'(ev_code), 32'h07);
    cycles(4);
    ev_ready = 1'b0;
    chk("ovr_drained", 32'(ev_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset with events queued and a count in flight
    sw = 16'h0012;
    cycles(8);
    sw = 16'h0002;
    cycles(3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_valid", 32'(ev_valid), 32'd0);
    chk("arst_stable", 32'(sw_stable), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    chk("arst_stable_e5", 32'(sw_stable), 32'd0);
    cycle();
    chk("arst_stable_e6", 32'(sw_stable), 32'h0002);
    cycle();
    chk("arst_valid_ev", 32'(ev_valid), 32'd1);
    chk("arst_code", 32'(ev_code), 32'h11);

    // Random switch activity and consumer back-pressure
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) sw[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) sw[$urandom_range(8, 15)] ^= 1'b1;
      ev_ready = ($urandom_range(0, 3) == 0);
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
